// File: rtl/mul_seq_pkg.sv
// Shared constants and types for the sequential shift-add multiplier.
package mul_seq_pkg;

  localparam int MUL_ITERS = 32;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_NOR = 3'b101;
  localparam logic [2:0] ALU_SUB = 3'b110;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    NEG_IN  = 3'd1,
    LOOP    = 3'd2,
    NEG_OUT = 3'd3,
    DONE    = 3'd4
  } state_t;

  typedef struct packed {
    logic        is_signed;
    logic [31:0] a;
    logic [31:0] b;
  } mul_req_t;

endpackage

// File: rtl/alu.sv
// 32-bit ALU; the single adder in the multiplier datapath.
module alu
  import mul_seq_pkg::*;
(
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  ALUop,
  output logic [31:0] Result,
  output logic        Overflow,
  output logic        Zero,
  output logic        CarryOut
);

  logic [31:0] b_op;
  logic [32:0] sum;

  // ALUop[2] selects subtract: A + ~B + 1
  always_comb begin
    b_op = ALUop[2] ? ~B : B;
    sum  = {1'b0, A} + {1'b0, b_op} + {32'b0, ALUop[2]};
    case (ALUop)
      ALU_AND: Result = A & B;
      ALU_OR:  Result = A | B;
      ALU_NOR: Result = ~(A | B);
      default: Result = sum[31:0];
    endcase
  end

  assign CarryOut = sum[32];
  assign Overflow = (A[31] == b_op[31]) && (sum[31] != A[31]);
  assign Zero     = (Result == 32'd0);

endmodule

// File: rtl/mul_seq.sv
// Sequential 32x32 multiplier: sign-magnitude wrapper around a 32-step
// shift-add loop, all arithmetic routed through one shared alu.
module mul_seq
  import mul_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    is_signed,
  input  logic [DATA_WIDTH-1:0]   a,
  input  logic [DATA_WIDTH-1:0]   b,
  output logic                    busy,
  output logic                    done,
  output logic [2*DATA_WIDTH-1:0] prod
);

  localparam logic [5:0] LAST_ITER = 6'(MUL_ITERS - 1);

  state_t      state, state_nxt;
  logic [31:0] mcand, hi, lo;
  logic [5:0]  cnt;
  logic        neg, sgn;
  logic [63:0] prod_q;

  logic [31:0] alu_a, alu_b, alu_res;
  logic [2:0]  alu_op;
  logic        alu_co;
  logic        alu_ovf_unused, alu_zero_unused;

  alu u_alu (
    .A        (alu_a),
    .B        (alu_b),
    .ALUop    (alu_op),
    .Result   (alu_res),
    .Overflow (alu_ovf_unused),
    .Zero     (alu_zero_unused),
    .CarryOut (alu_co)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // cnt[0] doubles as the sub-step index inside the 2-cycle NEG states
  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    done      = (state == DONE);
    alu_a     = hi;
    alu_b     = mcand;
    alu_op    = ALU_ADD;
    case (state)
      IDLE: if (start) state_nxt = is_signed ? NEG_IN : LOOP;
      NEG_IN: begin
        alu_a  = '0;
        alu_b  = cnt[0] ? lo : mcand;
        alu_op = ALU_SUB;
        if (cnt[0]) state_nxt = LOOP;
      end
      LOOP: if (cnt == LAST_ITER) state_nxt = sgn ? NEG_OUT : DONE;
      NEG_OUT: begin
        if (!cnt[0]) begin
          // 64-bit negate: hi gets the +1 carry only when lo is zero
          if (lo == 32'd0) begin
            alu_a  = '0;
            alu_b  = hi;
            alu_op = ALU_SUB;
          end else begin
            alu_a  = hi;
            alu_b  = '0;
            alu_op = ALU_NOR;
          end
        end else begin
          alu_a     = '0;
          alu_b     = lo;
          alu_op    = ALU_SUB;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand  <= '0;
      hi     <= '0;
      lo     <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
      sgn    <= 1'b0;
      prod_q <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          mcand <= a;
          lo    <= b;
          hi    <= '0;
          sgn   <= is_signed;
          neg   <= 1'b0;
          cnt   <= '0;
        end
        NEG_IN: begin
          if (!cnt[0]) begin
            neg <= mcand[31] ^ lo[31];
            if (mcand[31]) mcand <= alu_res;
            cnt <= 6'd1;
          end else begin
            if (lo[31]) lo <= alu_res;
            cnt <= '0;
          end
        end
        LOOP: begin
          if (lo[0]) {hi, lo} <= {alu_co, alu_res, lo[31:1]};
          else       {hi, lo} <= {1'b0, hi, lo[31:1]};
          cnt <= (cnt == LAST_ITER) ? 6'd0 : cnt + 6'd1;
        end
        NEG_OUT: begin
          if (!cnt[0]) begin
            if (neg) hi <= alu_res;
            cnt <= 6'd1;
          end else begin
            if (neg) lo <= alu_res;
            cnt <= '0;
          end
        end
        DONE: prod_q <= {hi, lo};
        default: ;
      endcase
    end
  end

  assign prod = done ? {hi, lo} : prod_q;

endmodule

// File: tb/tb_mul_seq.sv
// Randomized self-checking bench for mul_seq against a plain-arithmetic model.
module tb_mul_seq;
  logic        clk, rst, start, is_signed;
  logic [31:0] a, b;
  logic        busy, done;
  logic [63:0] prod;

  int n_cmp = 0;
  int n_bad = 0;

  mul_seq #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .is_signed(is_signed),
    .a(a), .b(b), .busy(busy), .done(done), .prod(prod)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y,
                                          input logic s);
    logic signed [63:0] sx, sy;
    if (s) begin
      sx = $signed({{32{x[31]}}, x});
      sy = $signed({{32{y[31]}}, y});
      return 64'(sx * sy);
    end
    return {32'b0, x} * {32'b0, y};
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Issues one op in the current cycle and leaves the bench in the IDLE cycle after done.
  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_, input logic ts,
                        input logic [63:0] exp, input string tag);
    logic [63:0] prev;
    int n;
    bit held;
    prev = prod;
    held = 1;
    a = ta; b = tb_; is_signed = ts; start = 1'b1;
    tick();
    start = 1'b0;
    a = $urandom; b = $urandom; is_signed = 1'($urandom_range(0, 1));
    n = 1;
    chk({tag, "/busy"}, 64'(busy), 64'd1);
    while (!done && n < 60) begin
      if (prod !== prev || busy !== 1'b1) held = 0;
      tick();
      n++;
    end
    chk({tag, "/latency"}, 64'(n), ts ? 64'd37 : 64'd33);
    chk({tag, "/prod"}, prod, exp);
    chk({tag, "/hold"}, 64'(held), 64'd1);
    tick();
    chk({tag, "/idle"}, 64'({busy, done}), 64'd0);
    chk({tag, "/keep"}, prod, exp);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic        rs;
    rst = 1'b1; start = 1'b0; is_signed = 1'b0; a = '0; b = '0;
    repeat (3) tick();
    chk("reset/busy", 64'(busy), 64'd0);
    chk("reset/done", 64'(done), 64'd0);
    chk("reset/prod", prod, 64'd0);
    rst = 1'b0;

    run_op(32'd7, 32'd6, 1'b0, 64'h0000_0000_0000_002A, "u7x6");
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, "umax");
    run_op(32'hFFFF_FFFD, 32'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFF1, "s-3x5");
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001, "s-1x-1");
    run_op(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, "sminxmin");
    run_op(32'h8000_0000, 32'd1, 1'b1, 64'hFFFF_FFFF_8000_0000, "sminx1");
    run_op(32'd0, 32'h1234_5678, 1'b1, 64'd0, "szero");
    run_op(32'hDEAD_BEEF, 32'd0, 1'b0, 64'd0, "uzero");

    // abort: second start ignored, reset mid-op with a coincident start dropped
    a = 32'd9; b = 32'd9; is_signed = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 20; c++) begin
      if (c == 10) begin a = 32'd2; start = 1'b1; end
      else start = 1'b0;
      tick();
    end
    start = 1'b0;
    chk("abort/busy19", 64'({busy, done}), 64'b10);
    rst = 1'b1; start = 1'b1; a = 32'd5; b = 32'd5;
    tick();
    rst = 1'b0; start = 1'b0;
    chk("abort/busy", 64'(busy), 64'd0);
    chk("abort/done", 64'(done), 64'd0);
    chk("abort/prod", prod, 64'd0);
    tick();
    chk("abort/dropped", 64'(busy), 64'd0);
    run_op(32'd2, 32'd3, 1'b0, 64'd6, "u2x3");

    for (int i = 0; i < 40; i++) begin
      ra = pick();
      rb = pick();
      rs = 1'($urandom_range(0, 1));
      run_op(ra, rb, rs, ref_mul(ra, rb, rs), $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
